// File: rtl/result_fifo_pkg.sv
// Shared sizing for the result FIFO: default data width and depth, derived
// pointer/count widths, and the width of the optional dropped-offer counter.
package result_fifo_pkg;

  // Pointer width for a power-of-two depth (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width able to represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned DATA_W_DEFAULT = 20;
  localparam int unsigned DEPTH_DEFAULT  = 4;
  localparam int unsigned PTR_W_DEFAULT  = ptr_w(DEPTH_DEFAULT);
  localparam int unsigned CNT_W_DEFAULT  = cnt_w(DEPTH_DEFAULT);
  localparam int unsigned DROP_CNT_W     = 8;
  localparam int unsigned DROP_CNT_MAX   = (1 << DROP_CNT_W) - 1;

endpackage

// File: rtl/result_fifo_if.sv
// Handshake bundle between the upstream producer, the result FIFO and its
// consumer.
//   io_in_valid/io_in_bits/io_in_ready    : offer side (no retry on full)
//   io_out_valid/io_out_bits/io_out_ready : head-of-queue side
//   io_count                              : occupancy 0..DEPTH
//   io_drop_count                         : dropped offers, only when
//                                           RESULT_FIFO_STATS_EN is defined
// Modports: slave = the FIFO, master = the surrounding logic.
interface result_fifo_if
  import result_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT
);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic              io_in_valid;
  logic [DATA_W-1:0] io_in_bits;
  logic              io_in_ready;
  logic              io_out_valid;
  logic [DATA_W-1:0] io_out_bits;
  logic              io_out_ready;
  logic [CNT_W-1:0]  io_count;
`ifdef RESULT_FIFO_STATS_EN
  logic [DROP_CNT_W-1:0] io_drop_count;
`endif

  modport slave (
    input  io_in_valid, io_in_bits, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits, io_count
`ifdef RESULT_FIFO_STATS_EN
    , output io_drop_count
`endif
  );

  modport master (
    output io_in_valid, io_in_bits, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits, io_count
`ifdef RESULT_FIFO_STATS_EN
    , input io_drop_count
`endif
  );

endinterface

// File: rtl/result_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write word
//   raddr : read index
//   rdata : word at raddr (combinational)
module result_fifo_mem
  import result_fifo_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEFAULT,
  parameter  int unsigned DEPTH  = DEPTH_DEFAULT,
  localparam int unsigned PTR_W  = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read port.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/result_fifo.sv
// Result FIFO: buffers words from the upstream incrementer for a consumer.
// Offers made while full are dropped (the producer does not retry).
// Ready/valid are decoded from registered occupancy only, so there is no
// combinational path from io_out_ready to io_in_ready, and no bypass from
// input to output.
//   clock : sole clock, rising edge
//   reset : synchronous, active-high; clears pointers, count and drop count
//   io    : result_fifo_if.slave handshake bundle
// Build option: RESULT_FIFO_STATS_EN adds the saturating io_drop_count.
module result_fifo
  import result_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  result_fifo_if.slave  io
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready;
  logic              out_valid;
  logic              enq;
  logic              deq;
  logic [DATA_W-1:0] head_data;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != CNT_W'(0));
  assign enq       = io.io_in_valid & in_ready;
  assign deq       = out_valid & io.io_out_ready;

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (deq) begin
      head_d = head_q + PTR_W'(1);
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  result_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clock),
    .we    (enq & ~reset),
    .waddr (tail_q),
    .wdata (io.io_in_bits),
    .raddr (head_q),
    .rdata (head_data)
  );

  assign io.io_in_ready  = in_ready;
  assign io.io_out_valid = out_valid;
  assign io.io_out_bits  = out_valid ? head_data : '0;
  assign io.io_count     = count_q;

`ifdef RESULT_FIFO_STATS_EN
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  // Count offers discarded while full, saturating at the counter maximum.
  always_comb begin
    drop_d = drop_q;
    if (io.io_in_valid && !in_ready && (drop_q != DROP_CNT_W'(DROP_CNT_MAX))) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign io.io_drop_count = drop_q;
`endif

endmodule

// File: tb/tb_result_fifo.sv
// Randomised and directed stimulus for result_fifo with a queue-based
// reference model and a decoupled output scoreboard.
module tb_result_fifo;

  localparam int unsigned DW  = 20;
  localparam int unsigned DEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  result_fifo_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

  result_fifo #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clock (clk),
    .reset (rst),
    .io    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q [$];
  int            occ   = 0;
  int            drops = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: checks status outputs, then predicts the coming edge.
  always @(negedge clk) begin
    chk("io_count", longint'(bus.io_count), longint'(occ));
    chk("io_in_ready", longint'(bus.io_in_ready), longint'(occ < DEP));
    chk("io_out_valid", longint'(bus.io_out_valid), longint'(occ > 0));
`ifdef RESULT_FIFO_STATS_EN
    chk("io_drop_count", longint'(bus.io_drop_count), longint'(drops));
`endif
    if (rst) begin
      occ   = 0;
      drops = 0;
      exp_q.delete();
    end else begin
      bit take_in;
      bit take_out;
      take_in  = bus.io_in_valid && (occ < DEP);
      take_out = bus.io_out_ready && (occ > 0);
      if (bus.io_in_valid && !(occ < DEP) && drops < 255) drops++;
      if (take_in) exp_q.push_back(bus.io_in_bits);
      occ = occ + int'(take_in) - int'(take_out);
    end
  end

  // Output monitor: head data must match the expected queue front.
  always @(negedge clk) begin
    if (!bus.io_out_valid) begin
      chk("out_bits_idle", longint'(bus.io_out_bits), 0);
    end else if (!rst) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 1, 0);
      end else if (bus.io_out_ready) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        chk("out_bits_pop", longint'(bus.io_out_bits), longint'(e));
      end else begin
        chk("out_bits_head", longint'(bus.io_out_bits), longint'(exp_q[0]));
      end
    end
  end

  task automatic cyc(input bit r, input bit v, input logic [DW-1:0] b, input bit rdy);
    rst              = r;
    bus.io_in_valid  = v;
    bus.io_in_bits   = b;
    bus.io_out_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, DW'(base + i), 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    bus.io_in_valid  = 1'b0;
    bus.io_in_bits   = '0;
    bus.io_out_ready = 1'b0;
    do_reset();

    // Single word, then fill to full and drain in order.
    fill(1, 1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    do_reset();
    fill(4, 1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    drain(6);

    // Offers while full are dropped without disturbing contents.
    do_reset();
    fill(4, 'h10);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 20'hFFFFF, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    drain(5);

    // Steady-state enqueue+dequeue at count 2 across pointer wrap.
    do_reset();
    fill(2, 'h100);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, DW'('h200 + i), 1'b1);
    drain(3);

    // Reset mid-operation with an offer present.
    fill(3, 'h300);
    cyc(1'b1, 1'b1, DW'('h3AA), 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // Drop counter saturation.
    do_reset();
    fill(4, 'h400);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, DW'($urandom), 1'b0);
    drain(5);

    // Random traffic with occasional reset.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 60,
          DW'($urandom),
          $urandom_range(0, 99) < 45);
    end
    drain(6);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
